wb_regfile: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register outputs. Selects the writeback value (memory read data vs. ALU result) and commits it to a 2^REG_FILE_ADDR_LEN-entry architectural register file. Provides two decode-stage read ports with same-cycle write-to-read bypass. Keeps a retired-writeback counter for performance debug.

---
 rtl/wb_regfile.sv | 97 +++++++++
 tb/tb_wb_regfile.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage register file. Picks the writeback value (load data or ALU
//   result) and commits it to the architectural register file. Two
//   combinational decode-side read ports see a same-cycle write through a
//   bypass path. A free-running retire counter tracks writeback cycles.
//
// Ports:
//   clk          : clock, all state updates on posedge
//   rstn         : synchronous active-low reset
//   wb_en        : writeback enable from MEM/WB
//   mem_r_en     : 1 selects mem_read_val, 0 selects alu_res
//   wb_dest      : destination register index
//   alu_res      : ALU result from MEM/WB
//   mem_read_val : load data from MEM/WB
//   src1, src2   : decode-stage read addresses
//   reg1, reg2   : decode-stage read data (bypassed)
//   wb_value     : selected writeback value, to the forwarding unit
//   wb_commit    : a write to a nonzero register commits at the next edge
//   retire_count : number of wb_en cycles since reset (wraps silently)
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int WORD_LEN          = 32,
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int CNT_W             = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wb_en,
    input  logic                         mem_r_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input  logic [WORD_LEN-1:0]          alu_res,
    input  logic [WORD_LEN-1:0]          mem_read_val,
    input  logic [REG_FILE_ADDR_LEN-1:0] src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] src2,
    output logic [WORD_LEN-1:0]          reg1,
    output logic [WORD_LEN-1:0]          reg2,
    output logic [WORD_LEN-1:0]          wb_value,
    output logic                         wb_commit,
    output logic [CNT_W-1:0]             retire_count
);

    localparam int NUM_REGS = 2 ** REG_FILE_ADDR_LEN;

    logic [WORD_LEN-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]    retire_count_q;
    logic [CNT_W-1:0]    retire_count_d;

    // Writeback mux stays live even when wb_en is low; the forwarding unit
    // qualifies it with its own enable.
    assign wb_value = mem_r_en ? mem_read_val : alu_res;

    // Gating with rstn both suppresses the write and kills the bypass while
    // reset is held.
    assign wb_commit = rstn & wb_en & (wb_dest != '0);

    assign retire_count_d = retire_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign retire_count   = retire_count_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            retire_count_q <= '0;
        end else begin
            if (wb_commit) begin
                regs_q[wb_dest] <= wb_value;
            end
            // Counts retired instructions, including ones targeting r0.
            if (wb_en) begin
                retire_count_q <= retire_count_d;
            end
        end
    end

    // Read ports: r0 is forced to zero, then the in-flight write wins over
    // the stored value.
    always_comb begin
        reg1 = regs_q[src1];
        if (src1 == '0) begin
            reg1 = '0;
        end else if (wb_commit && (wb_dest == src1)) begin
            reg1 = wb_value;
        end
    end

    always_comb begin
        reg2 = regs_q[src2];
        if (src2 == '0) begin
            reg2 = '0;
        end else if (wb_commit && (wb_dest == src2)) begin
            reg2 = wb_value;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int WL = 32;
    localparam int AL = 5;
    localparam int CW = 4;

    logic          clk;
    logic          rstn;
    logic          wb_en;
    logic          mem_r_en;
    logic [AL-1:0] wb_dest;
    logic [WL-1:0] alu_res;
    logic [WL-1:0] mem_read_val;
    logic [AL-1:0] src1;
    logic [AL-1:0] src2;
    logic [WL-1:0] reg1;
    logic [WL-1:0] reg2;
    logic [WL-1:0] wb_value;
    logic          wb_commit;
    logic [CW-1:0] retire_count;

    wb_regfile #(.WORD_LEN(WL), .REG_FILE_ADDR_LEN(AL), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .wb_dest(wb_dest), .alu_res(alu_res), .mem_read_val(mem_read_val),
        .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
        .wb_value(wb_value), .wb_commit(wb_commit), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mask bits: [4] reg1, [3] reg2, [2] wb_value, [1] wb_commit, [0] retire_count
    typedef struct {
        string         name;
        logic [WL-1:0] r1;
        logic [WL-1:0] r2;
        logic [WL-1:0] wb;
        logic          c;
        logic [CW-1:0] cnt;
        logic [4:0]    mask;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic cmp(input string nm, input string field,
                       input logic [WL-1:0] act, input logic [WL-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle is a presentation;
    // sample mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[4]) cmp(e.name, "reg1", reg1, e.r1);
                if (e.mask[3]) cmp(e.name, "reg2", reg2, e.r2);
                if (e.mask[2]) cmp(e.name, "wb_value", wb_value, e.wb);
                if (e.mask[1]) cmp(e.name, "wb_commit", {31'b0, wb_commit}, {31'b0, e.c});
                if (e.mask[0]) cmp(e.name, "retire_count", {28'b0, retire_count}, {28'b0, e.cnt});
            end
        end
    end

    task automatic step(input string nm,
                        input logic rs, input logic we, input logic mr,
                        input logic [AL-1:0] d, input logic [WL-1:0] alu,
                        input logic [WL-1:0] mem,
                        input logic [AL-1:0] s1, input logic [AL-1:0] s2,
                        input logic [WL-1:0] e1, input logic [WL-1:0] e2,
                        input logic [WL-1:0] ewb, input logic ec,
                        input logic [CW-1:0] ecnt, input logic [4:0] mask);
        exp_t e;
        @(posedge clk);
        #1;
        rstn = rs; wb_en = we; mem_r_en = mr; wb_dest = d;
        alu_res = alu; mem_read_val = mem; src1 = s1; src2 = s2;
        e.name = nm; e.r1 = e1; e.r2 = e2; e.wb = ewb; e.c = ec;
        e.cnt = ecnt; e.mask = mask;
        q.push_back(e);
    endtask

    initial begin
        rstn = 1'b0; wb_en = 1'b0; mem_r_en = 1'b0; wb_dest = '0;
        alu_res = '0; mem_read_val = '0; src1 = '0; src2 = '0;

        // Reset held: writes and bypass suppressed, mux still live.
        step("rst_hold_we", 0, 1, 0, 5, 32'h000000AA, 32'h0, 5, 0,
             32'h0, 32'h0, 32'h000000AA, 0, 0, 5'b11111);
        step("rst_reads",   0, 0, 0, 0, 32'h0, 32'h0, 7, 31,
             32'h0, 32'h0, 32'h0, 0, 0, 5'b11111);
        // ALU writeback with same-cycle bypass.
        step("alu_wb_byp",  1, 1, 0, 5, 32'hDEADBEEF, 32'h12345678, 5, 7,
             32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1, 0, 5'b11111);
        // mem_r_en without wb_en: mux only, array read.
        step("alu_wb_arr",  1, 0, 1, 5, 32'h0, 32'h12345678, 5, 5,
             32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678, 0, 1, 5'b11111);
        // Load writeback, both ports on the same register.
        step("ld_wb_byp",   1, 1, 1, 9, 32'h00000099, 32'h0000A5A5, 9, 9,
             32'h0000A5A5, 32'h0000A5A5, 32'h0000A5A5, 1, 1, 5'b11111);
        step("ld_wb_arr",   1, 0, 0, 9, 32'h0, 32'h0, 9, 9,
             32'h0000A5A5, 32'h0000A5A5, 32'h0, 0, 2, 5'b11111);
        // r0 protection.
        step("r0_same",     1, 1, 0, 0, 32'hFFFFFFFF, 32'h0, 0, 5,
             32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 2, 5'b11111);
        step("r0_next",     1, 0, 0, 0, 32'h0, 32'h0, 0, 9,
             32'h0, 32'h0000A5A5, 32'h0, 0, 3, 5'b11111);
        // Back-to-back writes to r3.
        step("b2b_first",   1, 1, 0, 3, 32'h11, 32'h0, 3, 0,
             32'h11, 32'h0, 32'h11, 1, 3, 5'b11111);
        step("b2b_second",  1, 1, 0, 3, 32'h22, 32'h0, 3, 3,
             32'h22, 32'h22, 32'h22, 1, 4, 5'b11111);
        step("b2b_arr",     1, 0, 0, 0, 32'h0, 32'h0, 3, 5,
             32'h22, 32'hDEADBEEF, 32'h0, 0, 5, 5'b11111);
        // Reset mid-stream with wb_en: no bypass, array read, then cleared.
        step("mid_rst",     0, 1, 0, 3, 32'h33, 32'h0, 3, 9,
             32'h22, 32'h0000A5A5, 32'h33, 0, 5, 5'b11111);
        step("after_rst",   1, 0, 0, 0, 32'h0, 32'h0, 3, 9,
             32'h0, 32'h0, 32'h0, 0, 0, 5'b11111);
        // Counter wrap with CNT_W=4: 16 retires to r0.
        for (int i = 0; i < 16; i++) begin
            step($sformatf("wrap_%0d", i), 1, 1, 0, 0, WL'(i), 32'h0, 0, 3,
                 32'h0, 32'h0, WL'(i), 0, CW'(i), 5'b11111);
        end
        step("wrap_zero",   1, 0, 0, 0, 32'h0, 32'h0, 0, 0,
             32'h0, 32'h0, 32'h0, 0, 0, 5'b11111);
        // Highest register index.
        step("r31_byp",     1, 1, 1, 31, 32'h0, 32'h31313131, 4, 31,
             32'h0, 32'h31313131, 32'h31313131, 1, 0, 5'b11111);
        step("r31_arr",     1, 0, 0, 0, 32'h0, 32'h0, 31, 31,
             32'h31313131, 32'h31313131, 32'h0, 0, 1, 5'b11111);

        begin
            int budget;
            budget = 0;
            while (q.size() > 0 && budget < 100) begin
                @(posedge clk);
                budget++;
            end
            if (q.size() > 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", q.size());
            end
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
